// File: rtl/wb_etapa_param.sv
// Writeback stage: MEM/WB register with valid/stall/flush, result select, sub-word load extraction, r0 write suppression.
// Optional retirement counter (retirados_out) enabled by defining WB_CONTADOR_RETIRO_EN.
module wb_etapa_param #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_MEM,
  input  logic              reg_escribir_MEM,
  input  logic [1:0]        sel_resultado_MEM,
  input  logic [DATA_W-1:0] resultado_alu_MEM,
  input  logic [DATA_W-1:0] dato_mem_MEM,
  input  logic [DATA_W-1:0] pc_mas4_MEM,
  input  logic [DATA_W-1:0] inmediato_MEM,
  input  logic [1:0]        tam_carga_MEM,
  input  logic              sin_signo_MEM,
  input  logic [$clog2(DATA_W/8)-1:0] byte_off_MEM,
  input  logic [REG_AW-1:0] registro_destino_MEM,
  output logic              reg_write_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [DATA_W-1:0] dato_escribir_out,
  output logic              valid_WB
`ifdef WB_CONTADOR_RETIRO_EN
  ,
  output logic [31:0]       retirados_out
`endif
);

  localparam int OFF_W = $clog2(DATA_W/8);

  logic              validWb_q, validWb_d;
  logic              regWrite_q, regWrite_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] dato_q, dato_d;

  logic [OFF_W+2:0]  byteShift, halfShift, wordShift;
  logic [DATA_W-1:0] laneVal, cargaRaw, highMask, cargaExt;
  logic              signBit;

  // Sub-word load: shift the addressed lane down to bit 0, then OR in the sign extension mask.
  always_comb begin
    byteShift = {byte_off_MEM, 3'b000};
    halfShift = {byte_off_MEM[OFF_W-1:1], 4'b0000};
    wordShift = '0;
    if (DATA_W == 64) wordShift = (OFF_W+3)'({byte_off_MEM[OFF_W-1], 5'b00000});
    laneVal  = '0;
    cargaRaw = '0;
    highMask = '0;
    signBit  = 1'b0;
    case (tam_carga_MEM)
      2'd0: begin
        laneVal  = dato_mem_MEM >> byteShift;
        cargaRaw = DATA_W'(laneVal[7:0]);
        signBit  = laneVal[7];
        highMask = ~DATA_W'(8'hFF);
      end
      2'd1: begin
        laneVal  = dato_mem_MEM >> halfShift;
        cargaRaw = DATA_W'(laneVal[15:0]);
        signBit  = laneVal[15];
        highMask = ~DATA_W'(16'hFFFF);
      end
      default: begin
        if (DATA_W == 64 && tam_carga_MEM == 2'd3) begin
          cargaRaw = dato_mem_MEM;
        end else begin
          // On a 32-bit bus the mask is all zeros, so word loads never extend.
          laneVal  = dato_mem_MEM >> wordShift;
          cargaRaw = DATA_W'(laneVal[31:0]);
          signBit  = laneVal[31];
          highMask = ~DATA_W'(32'hFFFF_FFFF);
        end
      end
    endcase
    cargaExt = (signBit && !sin_signo_MEM) ? (cargaRaw | highMask) : cargaRaw;
  end

  // Next-state values for a normal load; an empty slot captures all zeros.
  always_comb begin
    validWb_d  = 1'b0;
    regWrite_d = 1'b0;
    rd_d       = '0;
    dato_d     = '0;
    if (valid_MEM) begin
      validWb_d  = 1'b1;
      regWrite_d = reg_escribir_MEM && (registro_destino_MEM != '0);
      rd_d       = registro_destino_MEM;
      case (sel_resultado_MEM)
        2'd0:    dato_d = resultado_alu_MEM;
        2'd1:    dato_d = cargaExt;
        2'd2:    dato_d = pc_mas4_MEM;
        default: dato_d = inmediato_MEM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validWb_q  <= 1'b0;
      regWrite_q <= 1'b0;
      rd_q       <= '0;
      dato_q     <= '0;
    end else if (flush_i) begin
      validWb_q  <= 1'b0;
      regWrite_q <= 1'b0;
      rd_q       <= '0;
      dato_q     <= '0;
    end else if (!stall_i) begin
      validWb_q  <= validWb_d;
      regWrite_q <= regWrite_d;
      rd_q       <= rd_d;
      dato_q     <= dato_d;
    end
  end

  assign valid_WB          = validWb_q;
  assign reg_write_out     = regWrite_q;
  assign rd_out            = rd_q;
  assign dato_escribir_out = dato_q;

`ifdef WB_CONTADOR_RETIRO_EN
  logic [31:0] retirados_q;

  // Counts only edges that actually capture a real instruction; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retirados_q <= '0;
    end else if (!flush_i && !stall_i && valid_MEM) begin
      retirados_q <= retirados_q + 32'd1;
    end
  end

  assign retirados_out = retirados_q;
`else
  // This build carries no retirement counter.
`endif

endmodule

// File: tb/tb_wb_etapa_param.sv
// Directed bench for wb_etapa_param (DATA_W=32): vector table plus reset, stall and flush sequences.
module tb_wb_etapa_param;

  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, valid_MEM, reg_escribir_MEM, sin_signo_MEM;
  logic [1:0]  sel_resultado_MEM, tam_carga_MEM, byte_off_MEM;
  logic [31:0] resultado_alu_MEM, dato_mem_MEM, pc_mas4_MEM, inmediato_MEM;
  logic [4:0]  registro_destino_MEM, rd_out;
  logic        reg_write_out, valid_WB;
  logic [31:0] dato_escribir_out;
`ifdef WB_CONTADOR_RETIRO_EN
  logic [31:0] retirados_out;
`endif

  int errors = 0;
  int checks = 0;
  int expCount = 0;

  wb_etapa_param #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_MEM(valid_MEM), .reg_escribir_MEM(reg_escribir_MEM),
    .sel_resultado_MEM(sel_resultado_MEM), .resultado_alu_MEM(resultado_alu_MEM),
    .dato_mem_MEM(dato_mem_MEM), .pc_mas4_MEM(pc_mas4_MEM), .inmediato_MEM(inmediato_MEM),
    .tam_carga_MEM(tam_carga_MEM), .sin_signo_MEM(sin_signo_MEM), .byte_off_MEM(byte_off_MEM),
    .registro_destino_MEM(registro_destino_MEM), .reg_write_out(reg_write_out),
    .rd_out(rd_out), .dato_escribir_out(dato_escribir_out), .valid_WB(valid_WB)
`ifdef WB_CONTADOR_RETIRO_EN
    , .retirados_out(retirados_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [31:0] alu, mem, pc, imm;
    logic [1:0]  tam;
    logic        sinSigno;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic        valid, we;
    logic        expValid, expWe;
    logic [4:0]  expRd;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input string name, input logic [1:0] sel, input logic [31:0] alu,
                              input logic [31:0] mem, input logic [1:0] tam, input logic ss,
                              input logic [1:0] off, input logic [4:0] rd, input logic valid,
                              input logic we, input logic eValid, input logic eWe,
                              input logic [31:0] eData);
    vec_t v;
    v.name = name; v.sel = sel; v.alu = alu; v.mem = mem;
    v.pc = 32'h0000_0104; v.imm = 32'hABCD_E000;
    v.tam = tam; v.sinSigno = ss; v.off = off; v.rd = rd; v.valid = valid; v.we = we;
    v.expValid = eValid; v.expWe = eWe; v.expRd = rd; v.expData = eData;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sel_resultado_MEM = v.sel; resultado_alu_MEM = v.alu; dato_mem_MEM = v.mem;
    pc_mas4_MEM = v.pc; inmediato_MEM = v.imm; tam_carga_MEM = v.tam;
    sin_signo_MEM = v.sinSigno; byte_off_MEM = v.off; registro_destino_MEM = v.rd;
    valid_MEM = v.valid; reg_escribir_MEM = v.we;
  endtask

  task automatic checkOutput(input string name, input logic eValid, input logic eWe,
                             input logic [4:0] eRd, input logic [31:0] eData, input logic checkRd);
    checkVal({name, ".valid"}, 32'(valid_WB), 32'(eValid));
    checkVal({name, ".we"}, 32'(reg_write_out), 32'(eWe));
    if (checkRd) checkVal({name, ".rd"}, 32'(rd_out), 32'(eRd));
    checkVal({name, ".data"}, dato_escribir_out, eData);
`ifdef WB_CONTADOR_RETIRO_EN
    checkVal({name, ".retired"}, retirados_out, 32'(expCount));
`endif
  endtask

  initial begin
    vecs[0]  = mk("alu",       2'd0, 32'h1234_5678, 32'h0,          2'd2, 1'b0, 2'd0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
    vecs[1]  = mk("lb_off3",   2'd1, 32'h0,         32'h80FF_7F01,  2'd0, 1'b0, 2'd3, 5'd3,  1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FF80);
    vecs[2]  = mk("lbu_off3",  2'd1, 32'h0,         32'h80FF_7F01,  2'd0, 1'b1, 2'd3, 5'd3,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
    vecs[3]  = mk("lb_off0",   2'd1, 32'h0,         32'h80FF_7F01,  2'd0, 1'b0, 2'd0, 5'd4,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0001);
    vecs[4]  = mk("lb_off1",   2'd1, 32'h0,         32'h80FF_7F01,  2'd0, 1'b0, 2'd1, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_007F);
    vecs[5]  = mk("lb_off2",   2'd1, 32'h0,         32'h80FF_7F01,  2'd0, 1'b0, 2'd2, 5'd6,  1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    vecs[6]  = mk("lh_off2",   2'd1, 32'h0,         32'h8001_0000,  2'd1, 1'b0, 2'd2, 5'd8,  1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_8001);
    vecs[7]  = mk("lh_off3",   2'd1, 32'h0,         32'h8001_0000,  2'd1, 1'b0, 2'd3, 5'd8,  1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_8001);
    vecs[8]  = mk("lhu_off0",  2'd1, 32'h0,         32'h1234_F00D,  2'd1, 1'b1, 2'd0, 5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_F00D);
    vecs[9]  = mk("lw_signed", 2'd1, 32'h0,         32'hDEAD_BEEF,  2'd2, 1'b0, 2'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    vecs[10] = mk("ld_on32",   2'd1, 32'h0,         32'hDEAD_BEEF,  2'd3, 1'b0, 2'd1, 5'd11, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    vecs[11] = mk("pc4",       2'd2, 32'h0,         32'h0,          2'd0, 1'b0, 2'd0, 5'd1,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0104);
    vecs[12] = mk("imm",       2'd3, 32'h0,         32'h0,          2'd0, 1'b0, 2'd0, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 32'hABCD_E000);
    vecs[13] = mk("r0_write",  2'd0, 32'hCAFE_0000, 32'h0,          2'd0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'hCAFE_0000);
    vecs[14] = mk("no_we",     2'd0, 32'h0000_00AA, 32'h0,          2'd0, 1'b0, 2'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_00AA);
    vecs[15] = mk("invalid",   2'd0, 32'hFFFF_FFFF, 32'h0,          2'd0, 1'b0, 2'd0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    applyStimulus(vecs[0]);
    #1 checkOutput("reset_init", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      if (vecs[i].valid) expCount++;
      @(negedge clk);
      checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expWe, vecs[i].expRd, vecs[i].expData,
                  vecs[i].expValid);
    end

    // Reset arriving while a write is on the port must clear outputs before any clock edge.
    applyStimulus(vecs[0]);
    expCount++;
    @(negedge clk);
    checkOutput("pre_reset", 1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
    #2 reset = 1'b1;
    expCount = 0;
    #1 checkOutput("reset_async", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk); reset = 1'b0;
    #1 checkOutput("reset_hold", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    expCount++;
    @(negedge clk);
    checkOutput("after_reset", 1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b1);

    // Stall twice with new inputs pending, then flush and stall together.
    applyStimulus(vecs[12]);
    stall_i = 1'b1;
    @(negedge clk);
    checkOutput("stall1", 1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
    @(negedge clk);
    checkOutput("stall2", 1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    flush_i = 1'b0; stall_i = 1'b0;
    expCount++;
    @(negedge clk);
    checkOutput("resume", 1'b1, 1'b1, 5'd31, 32'hABCD_E000, 1'b1);
    applyStimulus(vecs[11]);
    flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_only", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    flush_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
